// File: rtl/hack_mmio_memory.sv
// Hack data-memory map: RAM, screen RAM, keyboard FIFO, cycle timer and status
// register behind one CPU data port, plus a read-only screen port for video.
module hack_mmio_memory #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 15,
   parameter int unsigned RAM_AW    = 14,
   parameter int unsigned SCR_AW    = 13,
   parameter int unsigned KBD_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] out,
   input  logic [SCR_AW-1:0] scr_addr,
   output logic [DATA_W-1:0] scr_data,
   input  logic [DATA_W-1:0] kbd_data,
   input  logic              kbd_valid,
   output logic              kbd_ready
);

   localparam int unsigned KAW = $clog2(KBD_DEPTH);
   localparam logic [ADDR_W-1:0] KBD_ADDR    = ADDR_W'((1 << (ADDR_W-1)) + (1 << SCR_AW));
   localparam logic [ADDR_W-1:0] TIMER_ADDR  = KBD_ADDR + ADDR_W'(1);
   localparam logic [ADDR_W-1:0] STATUS_ADDR = KBD_ADDR + ADDR_W'(2);

   logic [DATA_W-1:0] ram  [2**RAM_AW];
   logic [DATA_W-1:0] scr  [2**SCR_AW];
   logic [DATA_W-1:0] fifo [KBD_DEPTH];

   logic [KAW-1:0]    rd_ptr, wr_ptr;
   logic [KAW:0]      count;
   logic              overflow;
   logic [DATA_W-1:0] timer;
   logic [DATA_W-1:0] status;

   logic is_ram, is_scr, is_kbd, is_timer, is_status;
   logic empty, full, push, pop;

   // Screen window is the upper half of the map, below the first register.
   assign is_ram    = (address[ADDR_W-1:RAM_AW] == '0);
   assign is_scr    = address[ADDR_W-1] && (address[ADDR_W-2:SCR_AW] == '0);
   assign is_kbd    = (address == KBD_ADDR);
   assign is_timer  = (address == TIMER_ADDR);
   assign is_status = (address == STATUS_ADDR);

   assign empty     = (count == '0);
   assign full      = (count == (KAW+1)'(KBD_DEPTH));
   assign kbd_ready = !full;
   assign push      = kbd_valid && kbd_ready;
   assign pop       = load && is_kbd && !empty;

   always_comb begin
      status            = '0;
      status[0]         = !empty;
      status[1]         = full;
      status[2]         = overflow;
      status[3 +: KAW+1] = count;
   end

   always_comb begin
      out = '0;
      if (is_ram)
         out = ram[address[RAM_AW-1:0]];
      else if (is_scr)
         out = scr[address[SCR_AW-1:0]];
      else if (is_kbd)
         out = empty ? '0 : fifo[rd_ptr];
      else if (is_timer)
         out = timer;
      else if (is_status)
         out = status;
   end

   assign scr_data = scr[scr_addr];

   // Storage arrays are never cleared; reset only suppresses their writes.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (load && is_ram)
            ram[address[RAM_AW-1:0]] <= in;
         if (load && is_scr)
            scr[address[SCR_AW-1:0]] <= in;
         if (push)
            fifo[wr_ptr] <= kbd_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         timer    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + KAW'(1);
         if (pop)
            rd_ptr <= rd_ptr + KAW'(1);
         case ({push, pop})
            2'b10:   count <= count + (KAW+1)'(1);
            2'b01:   count <= count - (KAW+1)'(1);
            default: count <= count;
         endcase

         // A fresh overflow in the same cycle as a clear must survive.
         if (kbd_valid && full)
            overflow <= 1'b1;
         else if (load && is_status)
            overflow <= 1'b0;

         if (load && is_timer)
            timer <= in;
         else
            timer <= timer + DATA_W'(1);
      end
   end

endmodule

// File: doc/hack_mmio_memory.md
Name: hack_mmio_memory

Overview:
- Parametrised successor to the Hack data-memory map: general-purpose RAM, screen RAM, a buffered keyboard FIFO with valid/ready push handshake, a free-running cycle timer and a status register, all behind one CPU data port.
- The CPU data port is read combinationally and written synchronously.
- A second, read-only screen port serves the video scanner.
- Sits between the CPU data port (inM/outM/writeM/addressM) and the I/O devices.

Parameters:
- DATA_W, 16, data word width (>= 8).
- ADDR_W, 15, CPU address width.
- RAM_AW, 14, RAM address bits; RAM occupies 0 .. 2^RAM_AW-1; RAM_AW <= ADDR_W-1.
- SCR_AW, 13, screen address bits; SCR_BASE = 2^(ADDR_W-1); SCR_AW <= ADDR_W-2.
- KBD_DEPTH, 4, keyboard FIFO entries; power of two, >= 2.

Ports:
- clock, in, 1, single system clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- in, in, DATA_W, CPU write data.
- load, in, 1, CPU write enable.
- address, in, ADDR_W, CPU address.
- out, out, DATA_W, CPU read data, combinational from address and current state.
- scr_addr, in, SCR_AW, video read address.
- scr_data, out, DATA_W, screen word at scr_addr, combinational.
- kbd_data, in, DATA_W, key code from the keyboard device.
- kbd_valid, in, 1, key code present.
- kbd_ready, out, 1, FIFO can accept; equals !full.

Behaviour:
- Address decode, with KBD = SCR_BASE + 2^SCR_AW, TIMER = KBD+1, STATUS = KBD+2:
  - RAM: address < 2^RAM_AW.
  - Screen: SCR_BASE <= address < KBD.
  - Registers: KBD, TIMER, STATUS.
  - Any other address reads 0; writes to it are ignored.
- RAM/screen: a write with load=1 updates the word at the clock edge; a read in the same cycle returns the old word. Array contents are not cleared by reset.
- KBD read: returns the FIFO head, or 0 when the FIFO is empty.
- KBD pop: load=1 at KBD pops the head if the FIFO is non-empty; write data is ignored. A pop on an empty FIFO has no effect.
- Push: accepted when kbd_valid && kbd_ready. Entries are stored in arrival order. Read/write pointers are log2(KBD_DEPTH) bits and wrap modulo the depth; the count is log2(KBD_DEPTH)+1 bits.
- Simultaneous push and pop:
  - Non-empty and not full: count unchanged; head advances and the new entry is appended.
  - Full: kbd_ready=0, so only the pop takes effect; the push is refused that cycle.
  - Empty: only the push takes effect.
- Overflow: kbd_valid=1 while full sets a sticky overflow flag.
- TIMER:
  - Increments by 1 every cycle and wraps from 2^DATA_W-1 to 0.
  - load=1 at TIMER loads in, so the next-cycle read equals in, then it resumes incrementing.
  - A read in the same cycle as a load returns the pre-load value.
- STATUS read:
  - bit0 = non-empty.
  - bit1 = full.
  - bit2 = overflow.
  - bits[3 +: log2(KBD_DEPTH)+1] = count.
  - Remaining bits = 0.
- STATUS write: any load=1 at STATUS clears overflow. If overflow is set again in the same cycle, set wins.
- Reset, taking effect at the edge where reset=1:
  - FIFO empty (count=0, pointers 0); kbd_ready=1 from the next cycle.
  - Overflow = 0; TIMER = 0.
  - All pushes, pops and writes presented in a reset cycle are discarded, including RAM/screen writes.
  - Reset in the middle of a FIFO fill drops all stored entries.
- Latency: reads have 0 cycles latency (combinational); writes and state updates have 1 edge.

Test Plan:
- Write 16'h1234 to RAM[5], then read address 5 -> out=16'h1234. Write 16'hFFFF to SCR_BASE+3, then scr_addr=3 -> scr_data=16'hFFFF. Address KBD+3 -> out=0.
- After reset, read KBD -> 0 and STATUS -> 0. Push 'A'(16'h41) then 'B'(16'h42) -> KBD reads 16'h41 and STATUS=16'h0011. Pop -> KBD reads 16'h42. Pop -> KBD reads 0 and STATUS=0.
- Push 4 codes (DEPTH=4) -> kbd_ready=0, STATUS=16'h0023. Hold kbd_valid one more cycle -> STATUS=16'h0027 and the 5th code is not stored. Write STATUS -> bit2 cleared. Pop with simultaneous kbd_valid -> count=3 and the push is refused.
- FIFO with 2 entries plus simultaneous push and pop -> count stays 2 and order is preserved. Repeat 10 times to exercise pointer wrap; the popped sequence matches the push order.
- After reset, read TIMER at cycle 3 -> 3. Write 16'hFFFE -> next cycle reads 16'hFFFE, then 16'hFFFF, then 0 (wrap).
- Assert reset with 3 FIFO entries and TIMER=100 -> next cycle STATUS=0, TIMER reads 0, kbd_ready=1, and RAM[5] still holds 16'h1234.
